sample_frame_buffer: RTL and testbench
======================================

// Module: sample_frame_buffer
// PURPOSE
//   Sits directly downstream of sampling_clk. Captures one sample_in word on each sampling strobe pulse.
//   Assembles consecutive samples into N-sample frames in a ping-pong pair of banks.
//   Streams each completed frame to the FFT_16 input stage over a valid/ready interface.
//   Drops samples and flags overflow when both banks are full.
// PARAMETERS
//   DATA_W  16  sample width, bits
//   N       16  samples per frame; power of two, >= 2
//   ADDR_W  $clog2(N)  index width, derived; not for override
// PORTS
//   clk            in   1       clock; all logic on rising edge
//   rst            in   1       reset, asynchronous, active-high
//   sample_strobe  in   1       1-cycle pulse from sampling_clk.sampling_signal
//   sample_in      in   DATA_W  sample word, valid in the strobe cycle
//   m_data         out  DATA_W  current frame sample
//   m_index        out  ADDR_W  position of m_data within frame, 0..N-1
//   m_last         out  1       high with m_valid when m_index == N-1
//   m_valid        out  1       m_data/m_index/m_last valid
//   m_ready        in   1       consumer accepts; transfer = m_valid & m_ready
//   overflow       out  1       sticky: at least one sample dropped
//   clear_ovf      in   1       clears overflow and drop_cnt
//   drop_cnt       out  8       dropped-sample count, saturates at 255
// BEHAVIOUR
//   Reset values (async rst): m_valid=0, m_last=0, m_index=0, m_data=0, overflow=0, drop_cnt=0.
//     Internal reset: wr_bank=0, rd_bank=0, wr_ptr=0, rd_ptr=0, full[1:0]=0. Bank contents: don't care.
//   Write side (on sample_strobe):
//     full[wr_bank]==0: bank[wr_bank][wr_ptr] <= sample_in; wr_ptr++.
//     When wr_ptr==N-1: full[wr_bank]<=1, wr_bank toggles, wr_ptr<=0.
//     full[wr_bank]==1: sample dropped; overflow<=1; drop_cnt++ (saturating).
//   Read side:
//     m_valid = full[rd_bank]. m_data = bank[rd_bank][rd_ptr]. m_index = rd_ptr.
//     All of these are combinational from registers.
//     On transfer: rd_ptr++. When rd_ptr==N-1: full[rd_bank]<=0, rd_bank toggles, rd_ptr<=0.
//     m_valid=1 & m_ready=0: all m_* outputs hold stable. m_valid never deasserts mid-frame.
//   Latency: strobe carrying sample N-1 at edge t -> m_valid=1, m_index=0 from edge t (next cycle).
//   Consumer releases a bank (transfer of last=1) at edge t: that bank is writable for a strobe at t+1.
//     A strobe in the same cycle as that release is judged on the pre-edge full[] value.
//   Simultaneous write and read: always target different banks, since a write requires full=0 and a read requires full=1.
//     Both updates apply in the same edge.
//   clear_ovf and drop in the same cycle: drop wins; overflow=1 and drop_cnt=1.
//   Frame order: frames are emitted in capture order. A partial frame is never emitted.
//   rst mid-frame or mid-readout: partial and pending frames are discarded. m_valid falls immediately (async).
//   sample_strobe held high for k cycles: treated as k strobes. sampling_clk never does this.
// STRUCTURE
//   Shared package fft_pkg: FFT_N=16, SAMPLE_W=16, DROP_CNT_W=8.
//     sample_frame_buffer defaults to these.
//   Sub-module sfb_bank: N x DATA_W flop array with write enable, write address and a combinational read mux.
//     Instantiated twice; top-level muxes m_data by rd_bank.
//   Top level holds pointers, full[1:0], bank selects, overflow logic and drop counter.
// TESTING
//   T1 Reset: rst pulse -> all outputs 0; 20 strobes with m_ready=0 -> m_valid=1 after 16th.
//     Then 4 more samples go to bank 1; overflow=0.
//   T2 Frame: strobes carry 0x0000..0x000F, m_ready=1 -> 16 transfers, m_data=m_index=0..15.
//     m_last only on index 15; m_valid rises one cycle after 16th strobe.
//   T3 Backpressure: m_ready toggling 1/0 each cycle mid-frame -> m_data/m_index stable while m_ready=0.
//     No duplicate or lost samples.
//   T4 Overflow: m_ready=0, 40 strobes -> banks hold samples 0..31; overflow=1, drop_cnt=8.
//     Raise m_ready -> frames 0..15 then 16..31.
//     clear_ovf with concurrent drop -> overflow=1, drop_cnt=1.
//   T5 Back-to-back: sampling_clk period=0 (strobe every cycle), m_ready=1 -> continuous frames.
//     Zero drops across 10 frames; frame order preserved.
//   T6 Reset mid-op: rst at sample 7 of frame 2 during readout of frame 1 -> m_valid=0 async.
//     Next emitted frame starts at the first post-reset sample.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants and helpers for the FFT front-end blocks.
// Bank selector enum and a saturating increment for event counters.
package fft_pkg;
  localparam int FFT_N      = 16;
  localparam int SAMPLE_W   = 16;
  localparam int DROP_CNT_W = 8;

  typedef enum logic {
    BANK0 = 1'b0,
    BANK1 = 1'b1
  } bank_e;

  function automatic bank_e other_bank(input bank_e b);
    return (b == BANK0) ? BANK1 : BANK0;
  endfunction

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/sfb_bank.sv
// One frame bank: N x DATA_W flop array, single write port, combinational read mux.
// Contents are intentionally not reset; the full flags gate every read.
module sfb_bank #(
  parameter int DATA_W = 16,
  parameter int N      = 16,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/sample_frame_buffer.sv
// Ping-pong frame assembler: captures strobed samples into N-sample frames and
// streams completed frames out over valid/ready, dropping samples when both banks are full.
module sample_frame_buffer
  import fft_pkg::*;
#(
  parameter int    DATA_W = SAMPLE_W,
  parameter int    N      = FFT_N,
  localparam int   ADDR_W = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_strobe,
  input  logic [DATA_W-1:0]     sample_in,
  output logic [DATA_W-1:0]     m_data,
  output logic [ADDR_W-1:0]     m_index,
  output logic                  m_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  overflow,
  input  logic                  clear_ovf,
  output logic [DROP_CNT_W-1:0] drop_cnt
);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

  bank_e             wr_bank, rd_bank;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [1:0]        full;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              wr_en, drop, xfer, wr_done, rd_done;

  // Read and write always hit different banks, so both full[] updates can share an edge.
  assign wr_en   = sample_strobe & ~full[wr_bank];
  assign drop    = sample_strobe &  full[wr_bank];
  assign xfer    = full[rd_bank] & m_ready;
  assign wr_done = wr_en & (wr_ptr == LAST_IDX);
  assign rd_done = xfer & (rd_ptr == LAST_IDX);

  sfb_bank #(.DATA_W(DATA_W), .N(N), .ADDR_W(ADDR_W)) u_bank0 (
    .clk   (clk),
    .we    (wr_en & (wr_bank == BANK0)),
    .waddr (wr_ptr),
    .wdata (sample_in),
    .raddr (rd_ptr),
    .rdata (rdata0)
  );

  sfb_bank #(.DATA_W(DATA_W), .N(N), .ADDR_W(ADDR_W)) u_bank1 (
    .clk   (clk),
    .we    (wr_en & (wr_bank == BANK1)),
    .waddr (wr_ptr),
    .wdata (sample_in),
    .raddr (rd_ptr),
    .rdata (rdata1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank  <= BANK0;
      rd_bank  <= BANK0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      full     <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_done ? '0 : wr_ptr + 1'b1;
        if (wr_done) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= other_bank(wr_bank);
        end
      end
      if (xfer) begin
        rd_ptr <= rd_done ? '0 : rd_ptr + 1'b1;
        if (rd_done) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= other_bank(rd_bank);
        end
      end
      // A drop coinciding with clear_ovf restarts the count at one.
      if (clear_ovf) begin
        overflow <= drop;
        drop_cnt <= drop ? DROP_CNT_W'(1) : '0;
      end else if (drop) begin
        overflow <= 1'b1;
        drop_cnt <= sat_inc(drop_cnt);
      end
    end
  end

  always_comb begin
    m_valid = full[rd_bank];
    m_index = rd_ptr;
    m_last  = m_valid & (rd_ptr == LAST_IDX);
    m_data  = '0;
    if (m_valid) m_data = (rd_bank == BANK1) ? rdata1 : rdata0;
  end
endmodule

// File: tb/tb_sample_frame_buffer.sv
// Bench for sample_frame_buffer: queue-based reference model checked every cycle,
// a table of fill/drain phases, directed corner sequences and a random soak.
module tb_sample_frame_buffer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_strobe = 1'b0;
  logic [15:0] sample_in = '0;
  logic [15:0] m_data;
  logic [3:0]  m_index;
  logic        m_last, m_valid;
  logic        m_ready = 1'b0;
  logic        overflow;
  logic        clear_ovf = 1'b0;
  logic [7:0]  drop_cnt;

  sample_frame_buffer #(.DATA_W(16), .N(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .sample_strobe (sample_strobe),
    .sample_in     (sample_in),
    .m_data        (m_data),
    .m_index       (m_index),
    .m_last        (m_last),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .overflow      (overflow),
    .clear_ovf     (clear_ovf),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: samples of completed-but-unread frames, plus the frame being captured.
  logic [15:0] done_q[$];
  logic [15:0] part_q[$];
  int unsigned rd_pos;
  bit          mdl_ovf;
  int unsigned mdl_cnt;
  logic [15:0] seq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    done_q.delete();
    part_q.delete();
    rd_pos  = 0;
    mdl_ovf = 0;
    mdl_cnt = 0;
  endtask

  task automatic model_step(input logic s, input logic [15:0] d, input logic r, input logic c);
    int unsigned banks_full;
    bit accept, valid;
    banks_full = (done_q.size() + 15) / 16;
    accept     = (banks_full < 2);
    valid      = (done_q.size() > 0);
    if (valid && r) begin
      void'(done_q.pop_front());
      rd_pos = (rd_pos + 1) % 16;
    end
    if (s && accept) begin
      part_q.push_back(d);
      if (part_q.size() == 16) begin
        foreach (part_q[i]) done_q.push_back(part_q[i]);
        part_q.delete();
      end
    end
    if (s && !accept) begin
      mdl_ovf = 1;
      mdl_cnt = c ? 1 : ((mdl_cnt < 255) ? mdl_cnt + 1 : 255);
    end else if (c) begin
      mdl_ovf = 0;
      mdl_cnt = 0;
    end
  endtask

  task automatic compare_model();
    bit v;
    v = (done_q.size() > 0);
    check("m_valid",  32'(m_valid),  32'(v));
    check("m_index",  32'(m_index),  v ? rd_pos : 0);
    check("m_last",   32'(m_last),   32'(v && rd_pos == 15));
    check("m_data",   32'(m_data),   v ? 32'(done_q[0]) : 0);
    check("overflow", 32'(overflow), 32'(mdl_ovf));
    check("drop_cnt", 32'(drop_cnt), mdl_cnt);
  endtask

  task automatic cycle(input logic s, input logic [15:0] d, input logic r, input logic c);
    sample_strobe = s;
    sample_in     = d;
    m_ready       = r;
    clear_ovf     = c;
    @(posedge clk);
    model_step(s, d, r, c);
    #1;
    compare_model();
  endtask

  task automatic strobe_next(input logic r);
    cycle(1'b1, seq, r, 1'b0);
    seq = seq + 16'd1;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic async_reset();
    sample_strobe = 1'b0;
    m_ready       = 1'b0;
    clear_ovf     = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_valid",    32'(m_valid),  0);
    check("rst_last",     32'(m_last),   0);
    check("rst_index",    32'(m_index),  0);
    check("rst_data",     32'(m_data),   0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_drop_cnt", 32'(drop_cnt), 0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    int unsigned n;
    logic        strobe;
    logic        ready;
    logic        exp_valid;
    logic [3:0]  exp_index;
    logic [15:0] exp_data;
    logic        exp_ovf;
    logic [7:0]  exp_cnt;
  } phase_t;

  phase_t phases[6];

  initial begin
    phases[0] = '{n: 15, strobe: 1, ready: 0, exp_valid: 0, exp_index: 0, exp_data: 16'h0000, exp_ovf: 0, exp_cnt: 0};
    phases[1] = '{n: 1,  strobe: 1, ready: 0, exp_valid: 1, exp_index: 0, exp_data: 16'h0000, exp_ovf: 0, exp_cnt: 0};
    phases[2] = '{n: 4,  strobe: 1, ready: 0, exp_valid: 1, exp_index: 0, exp_data: 16'h0000, exp_ovf: 0, exp_cnt: 0};
    phases[3] = '{n: 12, strobe: 1, ready: 0, exp_valid: 1, exp_index: 0, exp_data: 16'h0000, exp_ovf: 0, exp_cnt: 0};
    phases[4] = '{n: 8,  strobe: 1, ready: 0, exp_valid: 1, exp_index: 0, exp_data: 16'h0000, exp_ovf: 1, exp_cnt: 8};
    phases[5] = '{n: 32, strobe: 0, ready: 1, exp_valid: 0, exp_index: 0, exp_data: 16'h0000, exp_ovf: 1, exp_cnt: 8};

    model_reset();
    seq = '0;
    #1;
    async_reset();

    // Fill both banks, overflow with 8 drops, then drain frames 0..15 and 16..31.
    foreach (phases[p]) begin
      for (int unsigned k = 0; k < phases[p].n; k++) begin
        if (phases[p].strobe) strobe_next(phases[p].ready);
        else cycle(1'b0, 16'h0, phases[p].ready, 1'b0);
      end
      check($sformatf("ph%0d_valid", p), 32'(m_valid),  32'(phases[p].exp_valid));
      check($sformatf("ph%0d_index", p), 32'(m_index),  32'(phases[p].exp_index));
      check($sformatf("ph%0d_data", p),  32'(m_data),   32'(phases[p].exp_data));
      check($sformatf("ph%0d_ovf", p),   32'(overflow), 32'(phases[p].exp_ovf));
      check($sformatf("ph%0d_cnt", p),   32'(drop_cnt), 32'(phases[p].exp_cnt));
    end

    // clear_ovf alone, then clear_ovf concurrent with a drop, then saturation.
    cycle(1'b0, 16'h0, 1'b0, 1'b1);
    check("clear_ovf", 32'(overflow), 0);
    check("clear_cnt", 32'(drop_cnt), 0);
    for (int unsigned k = 0; k < 32; k++) strobe_next(1'b0);
    cycle(1'b1, 16'hDEAD, 1'b0, 1'b1);
    check("clr_drop_ovf", 32'(overflow), 1);
    check("clr_drop_cnt", 32'(drop_cnt), 1);
    for (int unsigned k = 0; k < 260; k++) strobe_next(1'b0);
    check("sat_cnt", 32'(drop_cnt), 255);
    cycle(1'b0, 16'h0, 1'b0, 1'b1);
    for (int unsigned k = 0; k < 32; k++) cycle(1'b0, 16'h0, 1'b1, 1'b0);
    check("drained", 32'(m_valid), 0);

    // Frame with known content, then backpressure toggling each cycle; outputs must hold while stalled.
    seq = 16'h0000;
    for (int unsigned k = 0; k < 16; k++) strobe_next(1'b0);
    check("t2_first", 32'(m_data), 32'h0000);
    for (int unsigned k = 0; k < 32; k++) begin
      logic [15:0] hd;
      logic [3:0]  hi;
      logic        hv;
      hd = m_data;
      hi = m_index;
      hv = m_valid;
      cycle(1'b0, 16'h0, (k % 2 == 1), 1'b0);
      if (k % 2 == 0 && hv) begin
        check("hold_data",  32'(m_data),  32'(hd));
        check("hold_index", 32'(m_index), 32'(hi));
      end
    end
    check("t3_empty", 32'(m_valid), 0);

    // Strobe every cycle with the consumer always ready: no drops over 10 frames.
    seq = 16'h1000;
    for (int unsigned k = 0; k < 160; k++) strobe_next(1'b1);
    for (int unsigned k = 0; k < 20; k++) cycle(1'b0, 16'h0, 1'b1, 1'b0);
    check("t5_drops", 32'(drop_cnt), 0);
    check("t5_ovf",   32'(overflow), 0);

    // Reset while frame 2 is being captured and frame 1 is mid-readout.
    seq = 16'h2000;
    for (int unsigned k = 0; k < 16; k++) strobe_next(1'b0);
    for (int unsigned k = 0; k < 7; k++) strobe_next(k % 2 == 0);
    check("t6_mid_valid", 32'(m_valid), 1);
    async_reset();
    seq = 16'hA000;
    for (int unsigned k = 0; k < 16; k++) strobe_next(1'b0);
    check("t6_post_valid", 32'(m_valid), 1);
    check("t6_post_data",  32'(m_data),  32'hA000);
    for (int unsigned k = 0; k < 16; k++) cycle(1'b0, 16'h0, 1'b1, 1'b0);

    // Random soak against the model.
    for (int unsigned k = 0; k < 2000; k++) begin
      cycle(($urandom_range(0, 9) < 6), 16'($urandom), ($urandom_range(0, 9) < 5),
            ($urandom_range(0, 49) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
